// File: rtl/psram_ctrl.sv
// psram_ctrl: single-byte read/write transaction controller for an octal
// (8-bit DQ, SDR) PSRAM. One request at a time: command byte, 24-bit address
// in three beats, then either one write data beat or READ_LAT wait beats
// followed by one read data beat. SCLK runs at clk_100mhz/2; each beat is two
// clocks (phase 0: SCLK low, new DQ; phase 1: SCLK high, PSRAM samples).
//
// Request handshake: i_stb is level sampled on every clk edge. It is accepted
// only on an edge where the controller is idle (o_busy=0); on that edge
// i_we/i_addr/i_data are latched. While o_busy=1, i_stb is ignored, not
// queued; the requester holds or reissues it. Read results appear on o_data
// together with a one-cycle o_data_ready pulse.
//
// The pad tristate (o_dq / o_dq_oe / i_dq) is resolved by the level above.
module psram_ctrl #(
  parameter int         INIT_CYCLES = 15000,
  parameter int         READ_LAT    = 6,
  parameter int         CSH_CYCLES  = 2,
  parameter logic [7:0] CMD_READ    = 8'h03,
  parameter logic [7:0] CMD_WRITE   = 8'h02
) (
  input  logic        clk_100mhz,
  input  logic        rstn_i,
  input  logic        i_stb,
  input  logic        i_we,
  input  logic [23:0] i_addr,
  input  logic [7:0]  i_data,
  output logic        o_busy,
  output logic [7:0]  o_data,
  output logic        o_data_ready,
  output logic        o_psram_csn,
  output logic        o_psram_sclk,
  output logic [7:0]  o_dq,
  output logic        o_dq_oe,
  input  logic [7:0]  i_dq,
  output logic [2:0]  o_dbg_state
);

  // At least one turnaround beat between our last driven beat and the
  // PSRAM driving DQ, and at least one CSn-high clock between accesses.
  localparam int RLAT     = (READ_LAT   < 1) ? 1 : READ_LAT;
  localparam int CSH_N    = (CSH_CYCLES < 1) ? 1 : CSH_CYCLES;
  localparam int INIT_N   = (INIT_CYCLES < 1) ? 1 : INIT_CYCLES;
  localparam int CNT_MAX  = (INIT_N > RLAT) ? ((INIT_N > CSH_N) ? INIT_N : CSH_N)
                                            : ((RLAT > CSH_N) ? RLAT : CSH_N);
  localparam int CNT_W    = (CNT_MAX > 255) ? $clog2(CNT_MAX + 1) : 8;

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_N - 1);
  localparam logic [CNT_W-1:0] RLAT_LAST = CNT_W'(RLAT - 1);
  localparam logic [CNT_W-1:0] CSH_LAST  = CNT_W'(CSH_N - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(2);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_CMD   = 3'd2,
    S_ADDR  = 3'd3,
    S_WDATA = 3'd4,
    S_RWAIT = 3'd5,
    S_RDATA = 3'd6,
    S_CSH   = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic               we_q, we_d;
  logic [23:0]        addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         data_q, data_d;
  logic               ready_q, ready_d;

  // State, counters and latched request; everything returns to power-up
  // values on reset so an interrupted access never emits a data pulse.
  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic: beats advance on the phase-1 edge; counters count
  // beats in the serial states and clocks in INIT and CSH.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    ready_d = 1'b0;

    unique case (state_q)
      S_INIT: begin
        phase_d = 1'b0;
        if (cnt_q == INIT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_IDLE: begin
        phase_d = 1'b0;
        cnt_d   = '0;
        if (i_stb) begin
          we_d    = i_we;
          addr_d  = i_addr;
          wdata_d = i_data;
          state_d = S_CMD;
        end
      end

      S_CMD: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end
      end

      S_ADDR: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = we_q ? S_WDATA : S_RWAIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_WDATA: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          state_d = S_CSH;
          cnt_d   = '0;
        end
      end

      S_RWAIT: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (cnt_q == RLAT_LAST) begin
            cnt_d   = '0;
            state_d = S_RDATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_RDATA: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          // The PSRAM has held the byte across the rising SCLK edge; take it
          // on the clk edge that closes phase 1.
          data_d  = i_dq;
          ready_d = 1'b1;
          state_d = S_CSH;
          cnt_d   = '0;
        end
      end

      S_CSH: begin
        phase_d = 1'b0;
        if (cnt_q == CSH_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
        phase_d = 1'b0;
      end
    endcase
  end

  // Pad-side outputs decoded from registered state, so CSn and oe drop in
  // the same cycle the reset is asserted or the last driven beat ends.
  always_comb begin
    o_psram_csn  = 1'b1;
    o_psram_sclk = 1'b0;
    o_dq         = 8'h00;
    o_dq_oe      = 1'b0;

    unique case (state_q)
      S_CMD: begin
        o_psram_csn  = 1'b0;
        o_psram_sclk = phase_q;
        o_dq         = we_q ? CMD_WRITE : CMD_READ;
        o_dq_oe      = 1'b1;
      end
      S_ADDR: begin
        o_psram_csn  = 1'b0;
        o_psram_sclk = phase_q;
        o_dq_oe      = 1'b1;
        case (cnt_q[1:0])
          2'd0:    o_dq = addr_q[23:16];
          2'd1:    o_dq = addr_q[15:8];
          default: o_dq = addr_q[7:0];
        endcase
      end
      S_WDATA: begin
        o_psram_csn  = 1'b0;
        o_psram_sclk = phase_q;
        o_dq         = wdata_q;
        o_dq_oe      = 1'b1;
      end
      S_RWAIT, S_RDATA: begin
        o_psram_csn  = 1'b0;
        o_psram_sclk = phase_q;
      end
      default: begin
        o_psram_csn  = 1'b1;
        o_psram_sclk = 1'b0;
      end
    endcase
  end

  assign o_busy       = (state_q != S_IDLE);
  assign o_data       = data_q;
  assign o_data_ready = ready_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_psram_ctrl.sv
// tb_psram_ctrl: directed bench for psram_ctrl with a small PSRAM model that
// records every byte presented on a rising SCLK edge and drives its read
// byte only during the beat the controller should capture.
module tb_psram_ctrl;

  logic        clk_100mhz = 1'b0;
  logic        rstn_i     = 1'b0;
  logic        i_stb      = 1'b0;
  logic        i_we       = 1'b0;
  logic [23:0] i_addr     = 24'h0;
  logic [7:0]  i_data     = 8'h0;
  logic        o_busy;
  logic [7:0]  o_data;
  logic        o_data_ready;
  logic        o_psram_csn;
  logic        o_psram_sclk;
  logic [7:0]  o_dq;
  logic        o_dq_oe;
  logic [7:0]  i_dq;
  logic [2:0]  o_dbg_state;

  int total = 0;
  int bad   = 0;

  // PSRAM model state
  int          beat_cnt = 0;
  int          last_n   = 0;
  logic [7:0]  mon_dq [0:15];
  logic        mon_oe [0:15];
  logic [7:0]  model_resp = 8'h00;
  int          ready_seen = 0;

  psram_ctrl dut (
    .clk_100mhz   (clk_100mhz),
    .rstn_i       (rstn_i),
    .i_stb        (i_stb),
    .i_we         (i_we),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .o_busy       (o_busy),
    .o_data       (o_data),
    .o_data_ready (o_data_ready),
    .o_psram_csn  (o_psram_csn),
    .o_psram_sclk (o_psram_sclk),
    .o_dq         (o_dq),
    .o_dq_oe      (o_dq_oe),
    .i_dq         (i_dq),
    .o_dbg_state  (o_dbg_state)
  );

  // clock
  always #5 clk_100mhz = ~clk_100mhz;

  // Read byte is valid only after the 11th rising SCLK edge (cmd + 3 addr
  // + 6 wait beats + data beat), i.e. exactly when a correct controller
  // captures it.
  assign i_dq = (!o_psram_csn && beat_cnt == 11) ? model_resp : 8'hEE;

  // record bytes presented on each rising SCLK edge of a CSn-low window
  always @(posedge o_psram_sclk or posedge o_psram_csn) begin
    if (o_psram_csn) begin
      last_n   = beat_cnt;
      beat_cnt = 0;
    end else begin
      if (beat_cnt < 16) begin
        mon_dq[beat_cnt] = o_dq;
        mon_oe[beat_cnt] = o_dq_oe;
      end
      beat_cnt = beat_cnt + 1;
    end
  end

  always @(negedge clk_100mhz) begin
    if (o_data_ready === 1'b1) ready_seen = ready_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count clocks from the current point until o_busy drops.
  task automatic wait_init(input string tag);
    int n;
    int pin_bad;
    n = 0;
    pin_bad = 0;
    while (o_busy === 1'b1 && n < 20000) begin
      @(posedge clk_100mhz);
      #1;
      n++;
      if (o_psram_csn !== 1'b1 || o_dq_oe !== 1'b0) pin_bad++;
    end
    chk({tag, "_init_len"}, n, 15000);
    chk({tag, "_init_pins"}, pin_bad, 0);
  endtask

  // One complete transaction from an idle controller, sampled every cycle.
  task automatic txn(input string tag, input logic we, input logic [23:0] addr,
                     input logic [7:0] wd, input logic [7:0] resp,
                     input logic [7:0] exp_data);
    int n_low, n_tot, low, gap_bad, oe_bad, busy_bad, rdy_cnt, rdy_at;
    logic exp_oe;
    n_low = we ? 10 : 22;
    n_tot = n_low + 3;
    low = 0; gap_bad = 0; oe_bad = 0; busy_bad = 0; rdy_cnt = 0; rdy_at = 0;
    model_resp = resp;
    @(negedge clk_100mhz);
    i_stb = 1'b1; i_we = we; i_addr = addr; i_data = wd;
    @(posedge clk_100mhz);
    for (int k = 1; k <= n_tot; k++) begin
      @(negedge clk_100mhz);
      if (k == 1) i_stb = 1'b0;
      if (o_psram_csn === 1'b0) low++;
      if (k <= n_low && o_psram_csn !== 1'b0) gap_bad++;
      exp_oe = we ? (k <= 10) : (k <= 8);
      if (o_dq_oe !== exp_oe) oe_bad++;
      if (o_busy !== (k < n_tot)) busy_bad++;
      if (o_data_ready === 1'b1) begin
        rdy_cnt++;
        rdy_at = k;
      end
    end
    chk({tag, "_csn_low"}, low, n_low);
    chk({tag, "_csn_gap"}, gap_bad, 0);
    chk({tag, "_oe"}, oe_bad, 0);
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_rdy_cnt"}, rdy_cnt, we ? 0 : 1);
    if (!we) chk({tag, "_rdy_cycle"}, rdy_at, 23);
    chk({tag, "_data"}, o_data, exp_data);
    chk({tag, "_beats"}, last_n, we ? 5 : 11);
    chk({tag, "_b0"}, mon_dq[0], we ? 8'h02 : 8'h03);
    chk({tag, "_b1"}, mon_dq[1], addr[23:16]);
    chk({tag, "_b2"}, mon_dq[2], addr[15:8]);
    chk({tag, "_b3"}, mon_dq[3], addr[7:0]);
    chk({tag, "_b3_oe"}, mon_oe[3], 1'b1);
    if (we) begin
      chk({tag, "_b4"}, mon_dq[4], wd);
      chk({tag, "_b4_oe"}, mon_oe[4], 1'b1);
    end else begin
      chk({tag, "_b4_oe"}, mon_oe[4], 1'b0);
    end
  endtask

  initial begin
    int low, gap, snap;
    logic [7:0] csn_hist [1:26];

    // reset state
    rstn_i = 1'b0;
    #12;
    chk("rst_csn", o_psram_csn, 1'b1);
    chk("rst_sclk", o_psram_sclk, 1'b0);
    chk("rst_dq", o_dq, 8'h00);
    chk("rst_oe", o_dq_oe, 1'b0);
    chk("rst_busy", o_busy, 1'b1);
    chk("rst_data", o_data, 8'h00);
    chk("rst_rdy", o_data_ready, 1'b0);

    @(negedge clk_100mhz);
    rstn_i = 1'b1;
    wait_init("pwr");

    // basic write, basic read
    txn("wr1", 1'b1, 24'h123456, 8'hA5, 8'h00, 8'h00);
    txn("rd1", 1'b0, 24'h0000FF, 8'h00, 8'h3C, 8'h3C);

    // i_stb pulsed while busy is dropped; later request starts after CSH
    @(negedge clk_100mhz);
    i_stb = 1'b1; i_we = 1'b1; i_addr = 24'h0A0B0C; i_data = 8'h11;
    @(posedge clk_100mhz);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk_100mhz);
      csn_hist[k] = {7'd0, o_psram_csn};
      if (k == 1) i_stb = 1'b0;
      if (k == 4) begin
        i_stb = 1'b1; i_we = 1'b0; i_addr = 24'h777777; i_data = 8'h99;
      end
      if (k == 5) i_stb = 1'b0;
      if (k == 13) begin
        i_stb = 1'b1; i_we = 1'b1; i_addr = 24'h345678; i_data = 8'h5E;
      end
      if (k == 14) i_stb = 1'b0;
    end
    low = 0;
    gap = 0;
    for (int k = 1; k <= 26; k++) if (csn_hist[k][0] == 1'b0) low++;
    for (int k = 11; k <= 20; k++) begin
      if (csn_hist[k][0] == 1'b0) break;
      gap++;
    end
    chk("hold_csn_low_total", low, 20);
    chk("hold_csn_gap", gap, 3);
    chk("hold_busy_end", o_busy, 1'b0);
    chk("hold_beats", last_n, 5);
    chk("hold_b0", mon_dq[0], 8'h02);
    chk("hold_b1", mon_dq[1], 8'h34);
    chk("hold_b2", mon_dq[2], 8'h56);
    chk("hold_b3", mon_dq[3], 8'h78);
    chk("hold_b4", mon_dq[4], 8'h5E);
    chk("hold_data_kept", o_data, 8'h3C);

    // all-ones address read
    txn("rd_ff", 1'b0, 24'hFFFFFF, 8'h00, 8'h5A, 8'h5A);

    // async reset during the second address beat of a read
    model_resp = 8'hC3;
    @(negedge clk_100mhz);
    i_stb = 1'b1; i_we = 1'b0; i_addr = 24'h00ABCD; i_data = 8'h00;
    @(posedge clk_100mhz);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_100mhz);
      if (k == 1) i_stb = 1'b0;
    end
    chk("mid_csn_before", o_psram_csn, 1'b0);
    chk("mid_oe_before", o_dq_oe, 1'b1);
    snap = ready_seen;
    rstn_i = 1'b0;
    #1;
    chk("mid_csn", o_psram_csn, 1'b1);
    chk("mid_oe", o_dq_oe, 1'b0);
    chk("mid_sclk", o_psram_sclk, 1'b0);
    chk("mid_busy", o_busy, 1'b1);
    repeat (3) @(negedge clk_100mhz);
    rstn_i = 1'b1;
    wait_init("mid");
    repeat (30) @(negedge clk_100mhz);
    chk("mid_no_rdy", ready_seen - snap, 0);
    chk("mid_data_reset", o_data, 8'h00);

    // recovery after reset
    txn("rd_post", 1'b0, 24'h000001, 8'h00, 8'h81, 8'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psram_ctrl.md
# psram_ctrl

Single-byte transaction controller for the external octal PSRAM (8-bit DQ, SDR, SCLK = clk_100mhz/2). Sits between the 32-bit memory/peripheral bus decode and the PSRAM pads: accepts one read or write request at a time, serializes command, 24-bit address and data onto DQ, and returns read bytes with a one-cycle ready pulse. The pad tristate (o_dq/o_dq_oe/i_dq → io_psram_data0..7) is resolved in the top level.

## Interface
- INIT_CYCLES, 15000, power-up wait after reset before first transaction (150 µs)
- READ_LAT, 6, read wait beats between last address beat and data beat
- CSH_CYCLES, 2, minimum clk cycles CSn held high between transactions
- CMD_READ, 8'h03, read command byte
- CMD_WRITE, 8'h02, write command byte
- clk_100mhz  in  1  100 MHz system clock
- rstn_i  in  1  asynchronous, active-low reset
- i_stb  in  1  request strobe, synchronous to clk_100mhz, level sampled
- i_we  in  1  1 = write, 0 = read; sampled with i_stb
- i_addr  in  24  byte address; sampled with i_stb
- i_data  in  8  write data; sampled with i_stb
- o_busy  out  1  high while initializing or a transaction is in progress
- o_data  out  8  last read byte; held until next read completes
- o_data_ready  out  1  one-cycle pulse when o_data is updated
- o_psram_csn  out  1  chip select, active low
- o_psram_sclk  out  1  PSRAM clock
- o_dq  out  8  DQ drive value
- o_dq_oe  out  1  DQ output enable
- i_dq  in  8  DQ pad input

## Operation
- Reset values: o_psram_csn=1, o_psram_sclk=0, o_dq=0, o_dq_oe=0, o_busy=1, o_data=0, o_data_ready=0; state INIT, counter 0.
- States: INIT → IDLE → CMD → ADDR → (WDATA | RWAIT → RDATA) → CSH → IDLE.
- INIT: count INIT_CYCLES clocks, CSn high; then IDLE, o_busy=0.
- IDLE: on clk edge with i_stb=1, latch i_we/i_addr/i_data, set o_busy=1, enter CMD. i_stb while o_busy=1 is ignored (not queued); master must hold or reissue.
- Beat = 2 clocks: phase 0 SCLK=0 with new DQ driven; phase 1 SCLK=1 (PSRAM samples on rising edge). DQ changes only at phase 0.
- CMD: 1 beat, DQ = CMD_WRITE or CMD_READ, oe=1.
- ADDR: 3 beats, addr[23:16], [15:8], [7:0]; oe=1.
- WDATA: 1 beat, DQ = latched data, oe=1.
- RWAIT: READ_LAT beats, oe=0, SCLK still toggles, DQ ignored.
- RDATA: 1 beat, oe=0; i_dq captured on the clk edge ending phase 1 → o_data, o_data_ready=1 for the next cycle.
- CSH: CSn=1, SCLK=0, oe=0 for CSH_CYCLES clocks; then IDLE, o_busy=0.
- o_dq_oe falls to 0 in the same cycle the last driven beat ends; never overlaps PSRAM drive (RWAIT ≥1 beat enforced: READ_LAT=0 treated as 1).
- Async reset mid-transaction: outputs to reset values immediately (CSn=1, oe=0), state INIT with full INIT_CYCLES wait; no o_data_ready emitted.

## Timing
- Request accepted at edge T: CSn low and first CMD phase 0 from T+1.
- Write: CSn low 10 clocks (T+1..T+10); o_busy low at T+11+CSH_CYCLES.
- Read: CSn low 2·(5+READ_LAT) clocks; o_data_ready high in cycle T+1+2·(5+READ_LAT) (the first CSH cycle); o_busy low CSH_CYCLES later.
- Default read: stb→o_data_ready = 23 cycles; back-to-back throughput one access per 25 (read) / 13 (write) clocks.
- o_busy rises the cycle after acceptance; i_stb held high continuously issues a new transaction at each IDLE return.

## Test plan
- Reset, release rstn_i -> o_busy=1 for exactly 15000 clocks, CSn=1, oe=0 throughout, then o_busy=0.
- Write addr 24'h12_3456 data 8'hA5 -> DQ sequence 02,12,34,56,A5 on 5 SCLK rising edges, CSn low 10 clocks, oe=1 during all.
- Read addr 24'h00_00FF, PSRAM model returns 8'h3C after 6 wait beats -> DQ 03,00,00,FF, oe=0 after address, o_data=8'h3C with o_data_ready pulse 23 cycles after acceptance.
- i_stb pulsed while busy, then held high -> mid-transaction pulse ignored; held request starts exactly CSH_CYCLES after prior CSn rise.
- Assert rstn_i low during ADDR beat 2 -> CSn=1, oe=0 same cycle, no o_data_ready, full INIT wait repeated.
- Address 24'hFF_FFFF read -> all-ones address beats, correct data return.
